// File: rtl/dm_lane_mem.sv
// Byte-addressed data memory for the MEM stage: little-endian lane placement, load extension,
// misalignment flagging, registered reads and a sequential clear engine. Optional macro: DM_STICKY_ERR_EN.
module dm_lane_mem #(
  parameter int          AW       = 8,
  parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          init_start,
  output logic          busy,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [1:0]    mode,
  input  logic          sign_ext,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          rvalid,
  output logic          misalign,
  output logic          err_sticky,
  input  logic [AW-3:0] dbg_addr,
  output logic [31:0]   dbg_data
);

  localparam int            DEPTH    = 1 << (AW - 2);
  localparam logic [AW-3:0] PTR_LAST = {(AW-2){1'b1}};

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-3:0] r_ptr;
  logic [AW-3:0] w_ptr_nxt;
  logic          w_clear_we;
  logic          w_accept;

  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_rdata;
  logic          r_rvalid;
  logic          r_misalign;

  logic [AW-3:0] w_widx;
  logic          w_err;
  logic [3:0]    w_be;
  logic [31:0]   w_wlane;
  logic [31:0]   w_word;
  logic [15:0]   w_half;
  logic [7:0]    w_byte;
  logic [31:0]   w_load;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= S_CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // The clear engine owns the memory while in S_CLEAR; requests are only seen in S_IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_clear_we  = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clear_we = 1'b1;
        w_ptr_nxt  = r_ptr + 1'b1;
        if (r_ptr == PTR_LAST) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = '0;
        end
      end
      S_IDLE: begin
        if (init_start) begin
          w_state_nxt = S_CLEAR;
          w_ptr_nxt   = '0;
        end else begin
          w_accept = req_valid;
        end
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  assign busy   = (r_state == S_CLEAR);
  assign w_widx = addr[AW-1:2];

  always_comb begin
    w_err   = 1'b0;
    w_be    = 4'h0;
    w_wlane = wdata;
    case (mode)
      2'b00: begin
        w_err = (addr[1:0] != 2'b00);
        w_be  = 4'hF;
      end
      2'b01: begin
        w_err   = addr[0];
        w_be    = addr[1] ? 4'hC : 4'h3;
        w_wlane = {2{wdata[15:0]}};
      end
      2'b10: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wlane = {4{wdata[7:0]}};
      end
      default: w_err = 1'b1;
    endcase
  end

  assign w_word = r_mem[w_widx];
  assign w_half = addr[1] ? w_word[31:16] : w_word[15:0];
  assign w_byte = w_word[{addr[1:0], 3'b000} +: 8];

  always_comb begin
    w_load = '0;
    case (mode)
      2'b00:   w_load = w_word;
      2'b01:   w_load = {{16{sign_ext & w_half[15]}}, w_half};
      2'b10:   w_load = {{24{sign_ext & w_byte[7]}}, w_byte};
      default: w_load = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_clear_we) begin
      r_mem[r_ptr] <= INIT_VAL;
    end else if (w_accept && req_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_widx][i*8 +: 8] <= w_wlane[i*8 +: 8];
      end
    end
  end

  // Error loads still complete (rdata = 0) so the pipeline never waits on a missing response.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_rvalid   <= w_accept & ~req_we;
      r_misalign <= w_accept & w_err;
      if (w_accept && !req_we) r_rdata <= w_err ? 32'h0 : w_load;
    end
  end

  assign rdata    = r_rdata;
  assign rvalid   = r_rvalid;
  assign misalign = r_misalign;
  assign dbg_data = r_mem[dbg_addr];

`ifdef DM_STICKY_ERR_EN
  logic r_err_sticky;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_err_sticky <= 1'b0;
    end else if (r_state == S_IDLE && init_start) begin
      r_err_sticky <= 1'b0;
    end else if (w_accept && w_err) begin
      r_err_sticky <= 1'b1;
    end
  end

  assign err_sticky = r_err_sticky;
`else
  assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_dm_lane_mem.sv
// Self-checking bench for dm_lane_mem: directed vector table, random traffic against a byte-array
// model, and clear/reset sequences.
module tb_dm_lane_mem;

  localparam int AW = 8;
`ifdef DM_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clr_n;
  logic          init_start;
  logic          busy;
  logic          req_valid;
  logic          req_we;
  logic [1:0]    mode;
  logic          sign_ext;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          rvalid;
  logic          misalign;
  logic          err_sticky;
  logic [AW-3:0] dbg_addr;
  logic [31:0]   dbg_data;

  always #5 clk = ~clk;

  dm_lane_mem #(.AW(AW), .INIT_VAL(32'h0000_0000)) dut (
    .clk(clk), .clr_n(clr_n), .init_start(init_start), .busy(busy),
    .req_valid(req_valid), .req_we(req_we), .mode(mode), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
    .misalign(misalign), .err_sticky(err_sticky),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  int          nVectors = 0;
  int          nMiscompares = 0;
  logic [7:0]  mdlBytes [256];
  logic [31:0] mdlRdata = 32'h0;
  logic        mdlSticky = 1'b0;
  logic        expRvalid;
  logic        expMisalign;

  typedef struct {
    logic        we;
    logic [1:0]  mode;
    logic        se;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        expRvalid;
    logic        expMisalign;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs [20];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic modelErr(input logic [1:0] m, input logic [7:0] a);
    return (m == 2'd3) || (m == 2'd0 && (a % 4) != 0) || (m == 2'd1 && (a % 2) != 0);
  endfunction

  function automatic int modelSize(input logic [1:0] m);
    return (m == 2'd0) ? 4 : ((m == 2'd1) ? 2 : 1);
  endfunction

  function automatic logic [31:0] modelLoad(input logic [1:0] m, input logic se, input logic [7:0] a);
    longint v = 0;
    int     n = modelSize(m);
    for (int i = 0; i < n; i++) v += longint'(mdlBytes[int'(a) + i]) << (8 * i);
    if (se && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic modelStore(input logic [1:0] m, input logic [7:0] a, input logic [31:0] wd);
    int n = modelSize(m);
    for (int i = 0; i < n; i++) mdlBytes[int'(a) + i] = 8'(wd >> (8 * i));
  endtask

  function automatic logic [31:0] modelWord(input int k);
    return {mdlBytes[4*k+3], mdlBytes[4*k+2], mdlBytes[4*k+1], mdlBytes[4*k]};
  endfunction

  task automatic modelClear();
    for (int i = 0; i < 256; i++) mdlBytes[i] = 8'h00;
    mdlSticky = 1'b0;
  endtask

  // One request cycle while idle; expectations are taken from the model before the edge.
  task automatic applyStimulus(input logic v, input logic we, input logic [1:0] m, input logic se,
                               input logic [7:0] a, input logic [31:0] wd);
    logic err;
    err = modelErr(m, a);
    req_valid = v; req_we = we; mode = m; sign_ext = se; addr = a; wdata = wd;
    expRvalid   = v && !we;
    expMisalign = v && err;
    if (v && !we) mdlRdata = err ? 32'h0 : modelLoad(m, se, a);
    if (v && err && STICKY) mdlSticky = 1'b1;
    if (v && we && !err) modelStore(m, a, wd);
    step();
  endtask

  // Counts cycles with busy high while hammering dropped loads and a stray init_start.
  task automatic countBusy(output int n, output logic sawResp);
    n = 0;
    sawResp = 1'b0;
    while (busy && n < 200) begin
      req_valid = 1'b1; req_we = 1'b0; mode = 2'd0; addr = 8'h01;
      init_start = (n == 20);
      step();
      if (rvalid || misalign) sawResp = 1'b1;
      n++;
    end
    req_valid = 1'b0;
    init_start = 1'b0;
  endtask

  task automatic checkAllWords(input string tag);
    for (int k = 0; k < 64; k++) begin
      dbg_addr = k[5:0];
      #1;
      checkOutput($sformatf("%s dbg[%0d]", tag, k), dbg_data, modelWord(k));
    end
  endtask

  initial begin
    int   n;
    logic sawResp;

    vecs[0]  = '{1'b1, 2'd0, 1'b0, 8'h10, 32'h11223344, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 2'd2, 1'b0, 8'h12, 32'h000000AB, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 8'h10, 32'h0,        1'b1, 1'b0, 32'h11AB3344};
    vecs[3]  = '{1'b1, 2'd0, 1'b0, 8'h20, 32'h80FF7F01, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 2'd2, 1'b1, 8'h21, 32'h0,        1'b1, 1'b0, 32'h0000007F};
    vecs[5]  = '{1'b0, 2'd2, 1'b1, 8'h23, 32'h0,        1'b1, 1'b0, 32'hFFFFFF80};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 8'h22, 32'h0,        1'b1, 1'b0, 32'h000080FF};
    vecs[7]  = '{1'b0, 2'd1, 1'b1, 8'h22, 32'h0,        1'b1, 1'b0, 32'hFFFF80FF};
    vecs[8]  = '{1'b0, 2'd2, 1'b0, 8'h22, 32'h0,        1'b1, 1'b0, 32'h000000FF};
    vecs[9]  = '{1'b1, 2'd0, 1'b0, 8'h30, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 2'd1, 1'b0, 8'h31, 32'h0000BEEF, 1'b0, 1'b1, 32'h0};
    vecs[11] = '{1'b0, 2'd0, 1'b0, 8'h30, 32'h0,        1'b1, 1'b0, 32'hCAFEF00D};
    vecs[12] = '{1'b0, 2'd0, 1'b0, 8'h32, 32'h0,        1'b1, 1'b1, 32'h0};
    vecs[13] = '{1'b0, 2'd3, 1'b0, 8'h40, 32'h0,        1'b1, 1'b1, 32'h0};
    vecs[14] = '{1'b1, 2'd1, 1'b0, 8'h32, 32'h00001234, 1'b0, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 2'd0, 1'b0, 8'h30, 32'h0,        1'b1, 1'b0, 32'h1234F00D};
    vecs[16] = '{1'b0, 2'd1, 1'b1, 8'h10, 32'h0,        1'b1, 1'b0, 32'h00003344};
    vecs[17] = '{1'b1, 2'd2, 1'b0, 8'h13, 32'hFFFFFF5A, 1'b0, 1'b0, 32'h0};
    vecs[18] = '{1'b0, 2'd0, 1'b0, 8'h10, 32'h0,        1'b1, 1'b0, 32'h5AAB3344};
    vecs[19] = '{1'b1, 2'd3, 1'b0, 8'h44, 32'h12345678, 1'b0, 1'b1, 32'h0};

    clr_n = 1'b0; init_start = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    mode = 2'd0; sign_ext = 1'b0; addr = '0; wdata = '0; dbg_addr = '0;
    step();
    step();
    checkOutput("reset rdata", rdata, 32'h0);
    checkOutput("reset rvalid", {31'h0, rvalid}, 32'h0);
    checkOutput("reset misalign", {31'h0, misalign}, 32'h0);
    checkOutput("reset err_sticky", {31'h0, err_sticky}, 32'h0);
    checkOutput("reset busy", {31'h0, busy}, 32'h1);

    clr_n = 1'b1;
    countBusy(n, sawResp);
    checkOutput("initial busy cycles", n, 64);
    checkOutput("no response while busy", {31'h0, sawResp}, 32'h0);
    modelClear();
    checkAllWords("after reset clear");

    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, vecs[i].we, vecs[i].mode, vecs[i].se, vecs[i].addr, vecs[i].wdata);
      checkOutput($sformatf("vec%0d rvalid", i), {31'h0, rvalid}, {31'h0, vecs[i].expRvalid});
      checkOutput($sformatf("vec%0d misalign", i), {31'h0, misalign}, {31'h0, vecs[i].expMisalign});
      if (vecs[i].expRvalid) checkOutput($sformatf("vec%0d rdata", i), rdata, vecs[i].expRdata);
    end

    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 32'h0);
    checkOutput("hold rvalid", {31'h0, rvalid}, 32'h0);
    checkOutput("hold rdata", rdata, 32'h5AAB3344);
    checkOutput("sticky after errors", {31'h0, err_sticky}, {31'h0, STICKY});

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), $urandom);
      checkOutput($sformatf("rnd%0d rvalid", i), {31'h0, rvalid}, {31'h0, expRvalid});
      checkOutput($sformatf("rnd%0d misalign", i), {31'h0, misalign}, {31'h0, expMisalign});
      checkOutput($sformatf("rnd%0d rdata", i), rdata, mdlRdata);
      checkOutput($sformatf("rnd%0d sticky", i), {31'h0, err_sticky}, {31'h0, mdlSticky});
      dbg_addr = 6'($urandom_range(0, 63));
      #1;
      checkOutput($sformatf("rnd%0d dbg", i), dbg_data, modelWord(int'(dbg_addr)));
    end

    req_valid = 1'b1; req_we = 1'b0; mode = 2'd0; addr = 8'h01; init_start = 1'b1;
    step();
    checkOutput("init drops request rvalid", {31'h0, rvalid}, 32'h0);
    checkOutput("init drops request misalign", {31'h0, misalign}, 32'h0);
    checkOutput("init sticky cleared", {31'h0, err_sticky}, 32'h0);
    countBusy(n, sawResp);
    checkOutput("init_start busy cycles", n, 64);
    checkOutput("no response during clear", {31'h0, sawResp}, 32'h0);
    modelClear();
    checkAllWords("after init clear");

    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 8'h10, 32'h55AA55AA);
    applyStimulus(1'b1, 1'b0, 2'd3, 1'b0, 8'h10, 32'h0);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 8'h10, 32'h0);
    req_valid = 1'b0;
    checkOutput("preload rvalid", {31'h0, rvalid}, 32'h1);
    checkOutput("preload rdata", rdata, 32'h55AA55AA);
    checkOutput("preload sticky", {31'h0, err_sticky}, {31'h0, STICKY});
    clr_n = 1'b0;
    #2;
    checkOutput("mid-load reset rvalid", {31'h0, rvalid}, 32'h0);
    checkOutput("mid-load reset rdata", rdata, 32'h0);
    checkOutput("mid-load reset sticky", {31'h0, err_sticky}, 32'h0);
    checkOutput("mid-load reset busy", {31'h0, busy}, 32'h1);
    clr_n = 1'b1;
    countBusy(n, sawResp);
    checkOutput("post-load-reset busy cycles", n, 64);

    init_start = 1'b1;
    step();
    init_start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    clr_n = 1'b0;
    #2;
    checkOutput("mid-clear reset busy", {31'h0, busy}, 32'h1);
    clr_n = 1'b1;
    countBusy(n, sawResp);
    checkOutput("mid-clear reset busy cycles", n, 64);
    modelClear();
    checkAllWords("after mid-clear reset");

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
